bram_rd_stream_ctrl: RTL and testbench

Single-clock read controller that sits directly downstream of the asymmetric-width dual-port BRAM (read port in HIGH_PERFORMANCE mode, 3-register enable-gated read pipeline). On a start command it streams `num_words` consecutive read-width words, beginning at `start_addr`, out of the BRAM onto a valid/ready stream. A shadow valid pipeline tracks in-flight reads, and a credit-limited output FIFO absorbs downstream backpressure without losing or duplicating words. Both BRAM clocks are driven from this block's `clk`.

---
 rtl/bram_rd_stream_pkg.sv | 25 ++
 rtl/rd_skid_fifo.sv | 59 +++++
 rtl/bram_rd_stream_ctrl.sv | 118 +++++++++++
 tb/tb_bram_rd_stream_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_stream_pkg.sv
// Shared types and constants for the BRAM read streaming controller.
// Read latency, output FIFO depth and the address-width helper.
package bram_rd_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int C_RD_LATENCY     = 3;
  localparam int C_OUT_FIFO_DEPTH = 4;
  localparam int C_FIFO_CNT_W     = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Four-entry show-ahead FIFO holding read data plus its last flag.
// Exposes its occupancy so the issuer can budget credits.
module rd_skid_fifo
  import bram_rd_stream_pkg::*;
#(
  parameter int W = 33
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [W-1:0]            din,
  input  logic                    pop,
  output logic [W-1:0]            dout,
  output logic [C_FIFO_CNT_W-1:0] count_o
);

  localparam int PW = clog2(C_OUT_FIFO_DEPTH);

  logic [W-1:0]            mem_q [C_OUT_FIFO_DEPTH];
  logic [W-1:0]            mem_d [C_OUT_FIFO_DEPTH];
  logic [PW-1:0]           wr_q, wr_d;
  logic [PW-1:0]           rd_q, rd_d;
  logic [C_FIFO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < C_OUT_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout    = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/bram_rd_stream_ctrl.sv
// Streams consecutive words out of a 3-stage pipelined BRAM read port
// onto a valid/ready stream, credit-limited by a small output FIFO.
module bram_rd_stream_ctrl
  import bram_rd_stream_pkg::*;
#(
  parameter int C_RAM_RD_WIDTH = 32,
  parameter int C_RAM_RD_DEPTH = 1024,
  parameter int C_LEN_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [clog2(C_RAM_RD_DEPTH)-1:0]     start_addr,
  input  logic [C_LEN_WIDTH-1:0]               num_words,
  output logic                                 busy,
  output logic                                 done,
  output logic [clog2(C_RAM_RD_DEPTH)-1:0]     rdAddr,
  output logic                                 rden,
  input  logic [C_RAM_RD_WIDTH-1:0]            ram_dout,
  output logic [C_RAM_RD_WIDTH-1:0]            m_data,
  output logic                                 m_valid,
  output logic                                 m_last,
  input  logic                                 m_ready
);

  localparam int AW = clog2(C_RAM_RD_DEPTH);
  localparam int FW = C_RAM_RD_WIDTH + 1;
  localparam int L  = C_RD_LATENCY;
  localparam logic [AW-1:0] LAST_ADDR = AW'(C_RAM_RD_DEPTH - 1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0]  len_q, len_d;
  logic [L-1:0]            v_q, v_d;
  logic [L-1:0]            l_q, l_d;
  logic                    issue, is_last, credit_ok;
  logic                    push, pop;
  logic [C_FIFO_CNT_W-1:0] fifo_cnt;
  logic [FW-1:0]           fifo_dout;
  int                      inflight;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    v_d       = v_q;
    l_d       = l_q;
    inflight  = int'(fifo_cnt) - int'(pop) + $countones(v_q);
    credit_ok = inflight < C_OUT_FIFO_DEPTH;
    issue     = (state_q == S_RUN) && credit_ok;
    is_last   = (len_q == C_LEN_WIDTH'(1));
    rden      = issue | (|v_q);
    if (rden) begin
      v_d = {v_q[L-2:0], issue};
      l_d = {l_q[L-2:0], issue & is_last};
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = start_addr;
          len_d  = num_words;
          // an empty command still passes through DRAIN for one cycle
          state_d = (num_words == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          len_d = len_q - 1'b1;
          if (is_last) state_d = S_DRAIN;
          else addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (v_q == '0 && int'(fifo_cnt) == int'(pop)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      v_q     <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      v_q     <= v_d;
      l_q     <= l_d;
    end
  end

  assign push = v_q[L-1] & rden;
  assign pop  = m_valid & m_ready;

  rd_skid_fifo #(
    .W (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .din     ({l_q[L-1], ram_dout}),
    .pop     (pop),
    .dout    (fifo_dout),
    .count_o (fifo_cnt)
  );

  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign rdAddr            = addr_q;
  assign m_valid           = (fifo_cnt != '0);
  assign {m_last, m_data}  = m_valid ? fifo_dout : '0;

endmodule

// File: tb/tb_bram_rd_stream_ctrl.sv
// Directed-plus-random bench for bram_rd_stream_ctrl with a BRAM model
// and a queue-style expected-word reference.
module tb_bram_rd_stream_ctrl;

  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int LW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [9:0]    start_addr;
  logic [LW-1:0] num_words;
  logic          busy, done, rden, m_valid, m_last, m_ready;
  logic [9:0]    rdAddr;
  logic [W-1:0]  ram_dout, m_data;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] r0 = '0, r1 = '0, r2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rden) begin
      r0 <= mem[rdAddr];
      r1 <= r0;
      r2 <= r1;
    end
  end
  assign ram_dout = r2;

  bram_rd_stream_ctrl #(
    .C_RAM_RD_WIDTH (W),
    .C_RAM_RD_DEPTH (DEPTH),
    .C_LEN_WIDTH    (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .rdAddr     (rdAddr),
    .rden       (rden),
    .ram_dout   (ram_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, rden, 0);
    chk({tag, "_rdaddr"}, rdAddr, 0);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mlast"}, m_last, 0);
    chk({tag, "_mdata"}, m_data, 0);
  endtask

  // mode 0: ready always high; mode 1: 1-0-0-1 then random ready
  task automatic run_cmd(input int addr, input int n, input int mode,
                         input bit second, input int abort_cyc);
    int idx, done_cnt, last_hs, done_cyc, first_v;
    bit pv_stall;
    logic [W-1:0] pdata;
    logic plast;
    int aseq[$];
    int pat[4];
    pat = '{1, 0, 0, 1};
    idx = 0; done_cnt = 0; last_hs = -1; done_cyc = -1; first_v = -1;
    pv_stall = 0; pdata = '0; plast = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = addr[9:0];
    num_words  = n[LW-1:0];
    m_ready    = (mode == 0);
    @(negedge clk);
    chk("busy_in_start_cycle", busy, 0);
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (second && cyc == 2) begin
        start      = 1'b1;
        start_addr = 10'd500;
        num_words  = 16'd3;
      end
      if (mode == 1)
        m_ready = (cyc <= 4) ? (pat[cyc-1] != 0) : 1'($urandom_range(0, 1));
      if (cyc == abort_cyc) rst_n = 1'b0;
      @(negedge clk);
      if (abort_cyc > 0) begin
        if (cyc == abort_cyc + 1) begin
          chk_reset_outputs("abort");
          rst_n = 1'b1;
          return;
        end
        continue;
      end
      if (n == 0) begin
        chk("zero_len_rden", rden, 0);
        chk("zero_len_mvalid", m_valid, 0);
      end
      if (m_valid && first_v < 0) begin
        first_v = cyc;
        chk("mvalid_rise_cycle", cyc, 5);
      end
      if (pv_stall)
        chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, plast, pdata});
      chk("fifo_cnt_le4", 64'(dut.u_fifo.count_o <= 3'd4), 1);
      if (rden && (aseq.size() == 0 || aseq[$] != int'(rdAddr)))
        aseq.push_back(int'(rdAddr));
      if (m_valid && m_ready) begin
        if (idx < n) begin
          chk("word_data", m_data, mem[(addr + idx) % DEPTH]);
          chk("word_last", m_last, idx == n - 1);
        end else begin
          chk("extra_word", 1, 0);
        end
        idx++;
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("done_cycle", cyc, (n == 0) ? 2 : last_hs + 1);
        end
      end
      chk("busy", busy, (done_cyc < 0) || (cyc == done_cyc));
      pv_stall = m_valid && !m_ready;
      pdata    = m_data;
      plast    = m_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_pulses", done_cnt, 1);
    chk("word_count", idx, n);
    chk("addr_seq_len", aseq.size(), n);
    for (int i = 0; i < aseq.size() && i < n; i++)
      chk("addr_seq", aseq[i], (addr + i) % DEPTH);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    num_words  = '0;
    m_ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    run_cmd(10, 4, 0, 1'b0, -1);
    run_cmd(1022, 4, 0, 1'b0, -1);
    run_cmd(37, 16, 1, 1'b0, -1);
    run_cmd(200, 0, 0, 1'b0, -1);
    run_cmd(300, 8, 0, 1'b1, -1);
    run_cmd(400, 16, 0, 1'b0, 3);
    run_cmd(700, 2, 0, 1'b0, -1);
    for (int k = 0; k < 3; k++)
      run_cmd(int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(1, 40)), 1, 1'b0, -1);
    run_cmd(int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(1, 30)), 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
